arf_source_arbiter: RTL and testbench
=====================================

Name: arf_source_arbiter

Overview:
- Round-robin arbiter that merges num_sources producer channels onto one downstream channel.
- It uses the codebase's req/ack pull handshake: the consumer holds req; the producer pulses ack for one cycle with valid data.
- It sits between several producers (or async_operator outputs) and a single shared operator input or consumer, so one datapath input is time-shared.
- A per-grant timeout skips stalled sources.

Parameters:
- num_sources, 4, number of upstream channels (>=2).
- id_width, 2, width of source index; must satisfy 2**id_width >= num_sources.
- data_width, 32, data word width.
- timeout, 16, cycles to wait for upstream ack before abandoning a grant; 0 disables the timeout.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  asynchronous active-low reset.
- src_en  input  num_sources  per-source enable mask; sampled only in IDLE.
- din_req  output  num_sources  request to each producer; at most one bit high.
- din_ack  input  num_sources  one-cycle ack pulse from each producer.
- din  input  num_sources*data_width  producer data; source i at bits [data_width*(i+1)-1 : data_width*i].
- dout_req  input  1  downstream request (level).
- dout_ack  output  1  one-cycle ack pulse to downstream.
- dout  output  data_width  delivered word; holds until next delivery.
- dout_src  output  id_width  index of the source of dout; holds with dout.
- grant_count  output  32  number of words delivered since reset; wraps at 2**32.
- timeout_count  output  32  number of abandoned grants; wraps at 2**32.

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE, din_req=0, dout_ack=0, dout=0, dout_src=0, both counters=0, last-grant pointer=num_sources-1 (first grant goes to source 0).
- States: IDLE, REQ, DRAIN, ACK.
- IDLE, when dout_req=1, dout_ack=0, and src_en has at least one bit set:
  - Select the first enabled source after the pointer, cyclically.
  - Set sel to that source, raise din_req[sel], clear the wait counter, go to REQ.
  - If no source is enabled, stay in IDLE with all din_req=0.
- REQ:
  - If din_ack[sel]=1: capture din slice sel into dout, set dout_src=sel, drop din_req[sel], pointer=sel, grant_count+1, dout_ack=1, go to ACK.
  - Else if timeout!=0 and the wait counter equals timeout-1: drop din_req[sel], go to DRAIN.
  - Else increment the wait counter.
- DRAIN (exactly one cycle; absorbs an ack the producer issued against the req just dropped):
  - If din_ack[sel]=1: deliver exactly as in REQ, go to ACK.
  - Else: pointer=sel, timeout_count+1, go to IDLE.
- ACK: dout_ack returns to 0, go to IDLE. dout_ack is therefore never high on two consecutive cycles.
- Ignore din_ack from any non-selected source, and any din_ack in IDLE or ACK (no capture, no count).
- din_req[sel] drops on the edge that samples din_ack[sel], so a producer never sees req high while its own ack is low again.
- Minimum latency: dout_req high in IDLE → din_req at +1 → earliest din_ack at +2 → dout_ack at +3. Peak throughput is one word per 4 cycles.
- dout_req falling while in REQ does not abort the grant. The captured word is still delivered with a dout_ack pulse.
- src_en changes while in REQ, DRAIN or ACK do not affect the current grant.
- Fairness: after any grant or timeout of source k, the next search starts at k+1, wrapping num_sources-1 → 0.
- Reset asserted mid-grant immediately clears din_req and dout_ack; no data is delivered.

Test Plan:
- 4 always-ready producers with values 100/200/300/400 base, src_en=4'b1111, dout_req held 1 → dout_src sequence 0,1,2,3,0,…; dout_ack pulse every 4 cycles; grant_count=8 after 8 pulses; data matches each producer's own sequence.
- src_en=4'b0101 → only sources 0,2 granted, alternating; din_req[1] and din_req[3] never rise; src_en=0 → din_req stays 0, no dout_ack.
- timeout=16, producer 1 never acks → din_req[1] high exactly 16 cycles, then DRAIN, timeout_count=1; next grant goes to source 2; grant_count unaffected.
- Producer 1 acks on the DRAIN cycle (late, against the dropped req) → word delivered with dout_src=1, grant_count+1, timeout_count unchanged.
- Spurious din_ack[3]=1 while source 0 is selected → ignored; dout_src=0 with source 0's data.
- Assert rst low while in REQ with din_req[2]=1 → din_req=0, dout_ack=0, counters 0 without waiting for clk; after release the first grant goes to source 0.

Source files
------------

// File: rtl/arf_source_arbiter.sv
// arf_source_arbiter
//
// Round-robin arbiter that merges num_sources producer channels onto one
// downstream channel using the req/ack pull handshake: the consumer holds a
// level request, the producer answers with a one-cycle ack pulse carrying
// valid data. A per-grant timeout abandons stalled producers so the others
// keep flowing.
//
// Ports:
//   clk            clock, all state updates on the rising edge
//   rst            asynchronous active-low reset
//   src_en         per-source enable mask, sampled only while idle
//   din_req        request to each producer, at most one bit high
//   din_ack        one-cycle ack pulse from each producer
//   din            producer data, source i at [data_width*(i+1)-1 : data_width*i]
//   dout_req       downstream level request
//   dout_ack       one-cycle ack pulse to downstream
//   dout           delivered word, held until the next delivery
//   dout_src       source index of dout, held with dout
//   grant_count    words delivered since reset (wraps)
//   timeout_count  grants abandoned since reset (wraps)

module arf_source_arbiter #(
    parameter int num_sources = 4,
    parameter int id_width    = 2,
    parameter int data_width  = 32,
    parameter int timeout     = 16
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [num_sources-1:0]            src_en,
    output logic [num_sources-1:0]            din_req,
    input  logic [num_sources-1:0]            din_ack,
    input  logic [num_sources*data_width-1:0] din,
    input  logic                              dout_req,
    output logic                              dout_ack,
    output logic [data_width-1:0]             dout,
    output logic [id_width-1:0]               dout_src,
    output logic [31:0]                       grant_count,
    output logic [31:0]                       timeout_count
);

    // Wait counter only needs to reach timeout-1.
    localparam int wait_width = (timeout > 1) ? $clog2(timeout) : 1;
    localparam logic [wait_width-1:0] wait_last =
        (timeout > 0) ? wait_width'(timeout - 1) : '0;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        DRAIN,
        ACK
    } state_t;

    state_t                  state;
    logic [id_width-1:0]     sel;
    logic [id_width-1:0]     ptr;
    logic [wait_width-1:0]   wait_cnt;

    logic [id_width-1:0]     next_sel;
    logic                    any_en;
    logic [num_sources-1:0]  grant_onehot;
    logic                    sel_ack;
    logic [data_width-1:0]   sel_word;

    // Round-robin search: first enabled source strictly above the pointer,
    // otherwise wrap around and take the first enabled one at or below it.
    always_comb begin
        next_sel = '0;
        any_en   = 1'b0;
        for (int i = 0; i < num_sources; i++) begin
            if (!any_en && src_en[i] && (id_width'(i) > ptr)) begin
                next_sel = id_width'(i);
                any_en   = 1'b1;
            end
        end
        for (int i = 0; i < num_sources; i++) begin
            if (!any_en && src_en[i] && (id_width'(i) <= ptr)) begin
                next_sel = id_width'(i);
                any_en   = 1'b1;
            end
        end
    end

    // Decode of the chosen source plus the ack/data of the current grant;
    // acks from every other source are simply never looked at.
    always_comb begin
        grant_onehot = '0;
        sel_ack      = 1'b0;
        sel_word     = '0;
        for (int i = 0; i < num_sources; i++) begin
            grant_onehot[i] = (next_sel == id_width'(i));
            if (sel == id_width'(i)) begin
                sel_ack  = din_ack[i];
                sel_word = din[i*data_width +: data_width];
            end
        end
    end

    // Handshake FSM. DRAIN lasts one cycle after a timeout so that an ack
    // the producer issued against the just-dropped request is still taken.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= IDLE;
            sel           <= '0;
            ptr           <= id_width'(num_sources - 1);
            wait_cnt      <= '0;
            din_req       <= '0;
            dout_ack      <= 1'b0;
            dout          <= '0;
            dout_src      <= '0;
            grant_count   <= '0;
            timeout_count <= '0;
        end else begin
            dout_ack <= 1'b0;
            case (state)
                IDLE: begin
                    if (dout_req && !dout_ack && any_en) begin
                        sel      <= next_sel;
                        din_req  <= grant_onehot;
                        wait_cnt <= '0;
                        state    <= REQ;
                    end
                end
                REQ: begin
                    if (sel_ack) begin
                        dout        <= sel_word;
                        dout_src    <= sel;
                        din_req     <= '0;
                        ptr         <= sel;
                        grant_count <= grant_count + 32'd1;
                        dout_ack    <= 1'b1;
                        state       <= ACK;
                    end else if ((timeout != 0) && (wait_cnt == wait_last)) begin
                        din_req <= '0;
                        state   <= DRAIN;
                    end else begin
                        wait_cnt <= wait_cnt + wait_width'(1);
                    end
                end
                DRAIN: begin
                    if (sel_ack) begin
                        dout        <= sel_word;
                        dout_src    <= sel;
                        din_req     <= '0;
                        ptr         <= sel;
                        grant_count <= grant_count + 32'd1;
                        dout_ack    <= 1'b1;
                        state       <= ACK;
                    end else begin
                        ptr           <= sel;
                        timeout_count <= timeout_count + 32'd1;
                        state         <= IDLE;
                    end
                end
                ACK: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_arf_source_arbiter.sv
// tb_arf_source_arbiter
//
// Directed bench for arf_source_arbiter with four producer models driven
// from a single stimulus process one time unit after each rising edge.
// Producers answer a request after it has been visible for one full cycle,
// so the arbiter sees ack two edges after raising din_req.

module tb_arf_source_arbiter;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic [3:0]   src_en;
    logic [3:0]   din_req;
    logic [3:0]   din_ack;
    logic [127:0] din;
    logic         dout_req;
    logic         dout_ack;
    logic [31:0]  dout;
    logic [1:0]   dout_src;
    logic [31:0]  grant_count;
    logic [31:0]  timeout_count;

    int checks = 0;
    int errors = 0;

    logic [31:0] din_words [4];
    logic [3:0]  auto_mask;
    logic [3:0]  auto_ack;
    logic [3:0]  late_mask;
    logic [3:0]  req_prev;
    logic [3:0]  req_seen;
    logic        spur_on;
    int          base [4] = '{100, 200, 300, 400};
    int          prod_cnt [4];
    int          exp_cnt [4];
    int          req1_high;
    int          cyc;
    int          pulses;

    assign din = {din_words[3], din_words[2], din_words[1], din_words[0]};

    always #5 clk = ~clk;

    arf_source_arbiter #(
        .num_sources (4),
        .id_width    (2),
        .data_width  (32),
        .timeout     (16)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .src_en        (src_en),
        .din_req       (din_req),
        .din_ack       (din_ack),
        .din           (din),
        .dout_req      (dout_req),
        .dout_ack      (dout_ack),
        .dout          (dout),
        .dout_src      (dout_src),
        .grant_count   (grant_count),
        .timeout_count (timeout_count)
    );

    // Single comparison point for the whole bench.
    task automatic checkOutput(input string tag, input logic [63:0] actual,
                               input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
        end
    endtask

    // Advance one cycle and update the producer models.
    //   auto_mask: answers a request held for a full cycle
    //   late_mask: acks on the cycle its request was dropped (DRAIN)
    //   spur_on  : source 3 acks while source 0's request is fresh
    task automatic applyStimulus();
        logic [3:0] a_new;
        logic [3:0] l_new;
        logic       s_new;
        @(posedge clk);
        #1;
        a_new = auto_mask & din_req & req_prev & ~auto_ack;
        l_new = late_mask & req_prev & ~din_req;
        s_new = spur_on && din_req[0] && !req_prev[0];
        for (int i = 0; i < 4; i++) begin
            if (a_new[i[1:0]] || l_new[i[1:0]]) begin
                din_words[i] = base[i] + prod_cnt[i];
                prod_cnt[i]++;
            end
        end
        if (s_new) din_words[3] = 32'hDEAD_BEEF;
        auto_ack = a_new;
        din_ack  = a_new | l_new | {s_new, 3'b000};
        req_prev = din_req;
        req_seen = req_seen | din_req;
        if (din_req[1]) req1_high++;
    endtask

    // Step until a dout_ack pulse shows up, with a cycle budget.
    task automatic waitDelivery(output int cycles);
        bit got;
        got    = 1'b0;
        cycles = 0;
        while (!got && cycles < 80) begin
            applyStimulus();
            cycles++;
            if (dout_ack) got = 1'b1;
        end
        if (!got) checkOutput("deliveryWait", 0, 1);
    endtask

    // Delivered word must come from src with that producer's next value.
    task automatic expectWord(input int src, input string tag);
        checkOutput($sformatf("%s_src", tag), dout_src, src);
        checkOutput($sformatf("%s_data", tag), dout, base[src] + exp_cnt[src]);
        exp_cnt[src]++;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        src_en    = 4'b0000;
        din_ack   = 4'b0000;
        dout_req  = 1'b0;
        auto_mask = 4'b0000;
        auto_ack  = 4'b0000;
        late_mask = 4'b0000;
        req_prev  = 4'b0000;
        req_seen  = 4'b0000;
        spur_on   = 1'b0;
        req1_high = 0;
        for (int i = 0; i < 4; i++) begin
            din_words[i] = 32'd0;
            prod_cnt[i]  = 0;
            exp_cnt[i]   = 0;
        end

        // Reset state
        applyStimulus();
        applyStimulus();
        checkOutput("rst_din_req", din_req, 0);
        checkOutput("rst_dout_ack", dout_ack, 0);
        checkOutput("rst_dout", dout, 0);
        checkOutput("rst_dout_src", dout_src, 0);
        checkOutput("rst_grant", grant_count, 0);
        checkOutput("rst_timeout", timeout_count, 0);

        // Full round robin, all producers ready
        rst       = 1'b1;
        src_en    = 4'b1111;
        auto_mask = 4'b1111;
        dout_req  = 1'b1;
        for (int k = 0; k < 8; k++) begin
            waitDelivery(cyc);
            checkOutput((k == 0) ? "latency" : "interval", cyc, (k == 0) ? 3 : 4);
            expectWord(k % 4, "rr");
        end
        checkOutput("rr_grant", grant_count, 8);
        checkOutput("rr_timeout", timeout_count, 0);

        // Sparse enable: only sources 0 and 2
        src_en   = 4'b0101;
        req_seen = 4'b0000;
        for (int k = 0; k < 4; k++) begin
            waitDelivery(cyc);
            checkOutput("sparse_interval", cyc, 4);
            expectWord((k % 2 == 0) ? 0 : 2, "sparse");
        end
        checkOutput("sparse_masked_req", req_seen & 4'b1010, 0);

        // Nothing enabled: no requests, no deliveries
        src_en   = 4'b0000;
        req_seen = 4'b0000;
        pulses   = 0;
        for (int k = 0; k < 20; k++) begin
            applyStimulus();
            if (dout_ack) pulses++;
        end
        checkOutput("none_req", req_seen, 0);
        checkOutput("none_pulses", pulses, 0);
        checkOutput("none_grant", grant_count, 12);

        // Timeout on a silent source 1
        rst = 1'b0;
        applyStimulus();
        rst       = 1'b1;
        src_en    = 4'b1111;
        auto_mask = 4'b1101;
        waitDelivery(cyc);
        expectWord(0, "to_first");
        req1_high = 0;
        waitDelivery(cyc);
        expectWord(2, "to_next");
        checkOutput("to_req_cycles", req1_high, 16);
        checkOutput("to_timeout", timeout_count, 1);
        checkOutput("to_grant", grant_count, 2);

        // Source 1 answers only in the DRAIN cycle
        late_mask = 4'b0010;
        waitDelivery(cyc);
        expectWord(3, "late_pre3");
        waitDelivery(cyc);
        expectWord(0, "late_pre0");
        waitDelivery(cyc);
        expectWord(1, "late");
        checkOutput("late_grant", grant_count, 5);
        checkOutput("late_timeout", timeout_count, 1);
        late_mask = 4'b0000;

        // Spurious ack from source 3 while source 0 holds the grant
        src_en    = 4'b0001;
        auto_mask = 4'b0001;
        spur_on   = 1'b1;
        waitDelivery(cyc);
        expectWord(0, "spur");
        checkOutput("spur_grant", grant_count, 6);
        spur_on = 1'b0;

        // Reset in the middle of a grant to source 2
        src_en    = 4'b0100;
        auto_mask = 4'b0000;
        applyStimulus();
        applyStimulus();
        checkOutput("midrst_pre_req", din_req, 4'b0100);
        rst = 1'b0;
        #1;
        checkOutput("midrst_req", din_req, 0);
        checkOutput("midrst_ack", dout_ack, 0);
        checkOutput("midrst_grant", grant_count, 0);
        checkOutput("midrst_timeout", timeout_count, 0);
        #2;
        rst       = 1'b1;
        src_en    = 4'b1111;
        auto_mask = 4'b1111;
        waitDelivery(cyc);
        checkOutput("midrst_latency", cyc, 3);
        expectWord(0, "midrst_first");
        checkOutput("midrst_grant_after", grant_count, 1);

        // Downstream request dropped mid-grant still gets its word
        applyStimulus();
        applyStimulus();
        checkOutput("drop_req_active", din_req, 4'b0010);
        dout_req = 1'b0;
        waitDelivery(cyc);
        expectWord(1, "drop");
        req_seen = 4'b0000;
        pulses   = 0;
        for (int k = 0; k < 12; k++) begin
            applyStimulus();
            if (dout_ack) pulses++;
        end
        checkOutput("drop_idle_req", req_seen, 0);
        checkOutput("drop_idle_pulses", pulses, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
